// File: rtl/cp_removal_framer_if.sv
// Handshake bundle between the fine time synchroniser, the CP-removal framer and the FFT stage.
// The master modport is the framer's view; the slave modport is the environment's view.
interface cp_removal_framer_if #(
   parameter int IDXW = 8
) ();
   logic            cyc_i;
   logic            stb_i;
   logic            ack_o;
   logic [31:0]     dat_in;
   logic            cyc_o;
   logic            stb_o;
   logic            we_o;
   logic            ack_i;
   logic [31:0]     dat_out;
   logic            sym_first;
   logic            sym_last;
   logic [IDXW-1:0] sym_idx;
   logic            sym_err;
   logic            out_halt;

   modport master (
      input  cyc_i, stb_i, dat_in, ack_i,
      output ack_o, cyc_o, stb_o, we_o, dat_out,
      output sym_first, sym_last, sym_idx, sym_err, out_halt
   );

   modport slave (
      output cyc_i, stb_i, dat_in, ack_i,
      input  ack_o, cyc_o, stb_o, we_o, dat_out,
      input  sym_first, sym_last, sym_idx, sym_err, out_halt
   );
endinterface

// File: rtl/cp_removal_framer.sv
// Passes the leading LTS block, then strips the cyclic prefix from each data symbol and
// frames every retained NFFT-sample block with first/last/index markers for the FFT.
module cp_removal_framer #(
   parameter int NFFT = 64,
   parameter int NCP  = 16,
   parameter int NLTS = 64,
   parameter int IDXW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   cp_removal_framer_if.master  bus
);
   typedef enum logic [1:0] {IDLE, LTS, CP, DATA} state_t;

   localparam logic [6:0]      LTS_LAST = 7'(NLTS - 1);
   localparam logic [6:0]      CP_LAST  = 7'(NCP - 1);
   localparam logic [6:0]      FFT_LAST = 7'(NFFT - 1);
   localparam logic [IDXW-1:0] IDX_MAX  = '1;

   state_t          state_q, state_d;
   logic [6:0]      cnt_q, cnt_d;
   logic [IDXW-1:0] blk_q, blk_d;
   logic            cyc_o_q, cyc_o_d;
   logic            stb_q, stb_d;
   logic            first_q, first_d;
   logic            last_q, last_d;
   logic            err_q, err_d;
   logic [31:0]     dat_q, dat_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            out_halt, accept, emit, emit_first, emit_last;

   // ack_o is gated by the halt, so an accepted sample always has room in the output register
   assign out_halt = stb_q & ~bus.ack_i;
   assign accept   = bus.cyc_i & bus.stb_i & ~out_halt;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      blk_d      = blk_q;
      cyc_o_d    = cyc_o_q;
      err_d      = 1'b0;
      emit       = 1'b0;
      emit_first = 1'b0;
      emit_last  = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            state_d    = LTS;
            cnt_d      = 7'd1;
            blk_d      = '0;
            cyc_o_d    = 1'b1;
            emit       = 1'b1;
            emit_first = 1'b1;
         end
         LTS: if (accept) begin
            emit = 1'b1;
            if (cnt_q == LTS_LAST) begin
               emit_last = 1'b1;
               state_d   = CP;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         CP: if (accept) begin
            if (cnt_q == CP_LAST) begin
               state_d = DATA;
               cnt_d   = '0;
               if (blk_q != IDX_MAX) blk_d = blk_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         DATA: if (accept) begin
            emit       = 1'b1;
            emit_first = (cnt_q == '0);
            if (cnt_q == FFT_LAST) begin
               emit_last = 1'b1;
               state_d   = CP;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A packet ending on a block boundary (cnt==0 in CP or DATA) is clean
      if (state_q != IDLE && !bus.cyc_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         err_d   = (cnt_q != '0);
      end
      if (!bus.cyc_i && (!stb_q || bus.ack_i)) cyc_o_d = 1'b0;

      dat_d   = dat_q;
      stb_d   = stb_q;
      first_d = first_q;
      last_d  = last_q;
      idx_d   = idx_q;
      if (emit) begin
         dat_d   = bus.dat_in;
         stb_d   = 1'b1;
         first_d = emit_first;
         last_d  = emit_last;
         idx_d   = (state_q == IDLE) ? '0 : blk_q;
      end else if (!out_halt) begin
         stb_d   = 1'b0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         blk_q   <= '0;
         cyc_o_q <= 1'b0;
         stb_q   <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         cyc_o_q <= cyc_o_d;
         stb_q   <= stb_d;
         first_q <= first_d;
         last_q  <= last_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.ack_o     = accept;
   assign bus.cyc_o     = cyc_o_q;
   assign bus.stb_o     = stb_q;
   assign bus.we_o      = stb_q;
   assign bus.dat_out   = dat_q;
   assign bus.sym_first = first_q;
   assign bus.sym_last  = last_q;
   assign bus.sym_idx   = idx_q;
   assign bus.sym_err   = err_q;
   assign bus.out_halt  = out_halt;
endmodule

// File: tb/tb_cp_removal_framer.sv
// Directed bench for cp_removal_framer: table of packet scenarios scored against a
// sample-index reference model, plus a hand-written asynchronous reset sequence.
`timescale 1ns/1ps
module tb_cp_removal_framer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cp_removal_framer_if #(.IDXW(8)) bus ();

   cp_removal_framer #(.NFFT(64), .NCP(16), .NLTS(64), .IDXW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string name;
      int    n_total;     // accepted samples before cyc_i drops
      bit    stb_toggle;  // stb_i alternates 1,0
      int    stall_val;   // dat_out value at which ack_i is held low (-1 none)
      int    stall_len;
      int    exp_beats;
      int    exp_err;
      int    exp_max_idx;
   } vec_t;

   typedef struct {
      logic [31:0] dat;
      bit          first;
      bit          last;
      int          idx;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs[6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: sample n of the stream (0 = first LTS sample); returns 1 if it is retained
   function automatic bit model(input int n, output exp_t e);
      int m, p, s;
      e.dat = 32'(n); e.first = 1'b0; e.last = 1'b0; e.idx = 0;
      if (n < 64) begin
         e.first = (n == 0);
         e.last  = (n == 63);
         return 1'b1;
      end
      m = n - 64; p = m % 80; s = m / 80 + 1;
      if (p < 16) return 1'b0;
      e.first = (p == 16);
      e.last  = (p == 79);
      e.idx   = (s > 255) ? 255 : s;
      return 1'b1;
   endfunction

   task automatic run_pkt(input vec_t v);
      exp_t q[$];
      exp_t e, g;
      int   n = 0, cyc = 0, beats = 0, errp = 0, bad = 0, maxidx = 0;
      int   first_acc = -1, first_beat = -1, stall_rem = 0, stall_good = 0;
      bit   stall_done = 1'b0;
      int   budget = 3 * v.n_total + 100;
      string badmsg = "";
      for (int k = 0; k < budget + 8; k++) begin
         bit in_pkt;
         in_pkt = (n < v.n_total) && (k < budget);
         if (!in_pkt && k < budget) k = budget;  // jump to the drain phase
         @(negedge clk);
         cyc++;
         if (bus.sym_err) errp++;
         if (bus.stb_o && first_beat < 0) first_beat = cyc;
         if (stall_rem > 0) begin
            bus.ack_i = 1'b0; stall_rem--;
         end else if (in_pkt && v.stall_val >= 0 && !stall_done && bus.stb_o &&
                      bus.dat_out == 32'(v.stall_val)) begin
            bus.ack_i = 1'b0; stall_rem = v.stall_len - 1; stall_done = 1'b1;
         end else begin
            bus.ack_i = 1'b1;
         end
         bus.cyc_i  = in_pkt;
         bus.stb_i  = in_pkt && (v.stb_toggle ? cyc[0] : 1'b1);
         bus.dat_in = bus.stb_i ? 32'(n) : 32'hdeadbeef;
         #1;
         if (!bus.ack_i && v.stall_val >= 0 && bus.out_halt && !bus.ack_o &&
             bus.dat_out == 32'(v.stall_val)) stall_good++;
         if (bus.stb_o && bus.ack_i) begin
            beats++;
            if (int'(bus.sym_idx) > maxidx) maxidx = int'(bus.sym_idx);
            if (q.size() == 0) begin
               if (bad == 0) badmsg = $sformatf("extra beat dat=%0d", bus.dat_out);
               bad++;
            end else begin
               g = q.pop_front();
               if (bus.dat_out !== g.dat || bus.sym_first !== g.first ||
                   bus.sym_last !== g.last || int'(bus.sym_idx) != g.idx) begin
                  if (bad == 0)
                     badmsg = $sformatf("dat=%0d f=%0b l=%0b idx=%0d want dat=%0d f=%0b l=%0b idx=%0d",
                                        bus.dat_out, bus.sym_first, bus.sym_last, bus.sym_idx,
                                        g.dat, g.first, g.last, g.idx);
                  bad++;
               end
            end
         end
         if (bus.ack_o) begin
            if (first_acc < 0) first_acc = cyc;
            if (model(n, e)) q.push_back(e);
            n++;
         end
      end
      $display("pkt %s: accepted=%0d beats=%0d sym_err_pulses=%0d max_idx=%0d cyc_o=%0b",
               v.name, n, beats, errp, maxidx, bus.cyc_o);
      if (bad != 0) $display("  first bad beat in %s: %s", v.name, badmsg);
      chk({v.name, "/accepted"},     n, v.n_total);
      chk({v.name, "/beat_seq_bad"}, bad, 0);
      chk({v.name, "/beats"},        beats, v.exp_beats);
      chk({v.name, "/missing"},      q.size(), 0);
      chk({v.name, "/sym_err"},      errp, v.exp_err);
      chk({v.name, "/max_idx"},      maxidx, v.exp_max_idx);
      chk({v.name, "/latency"},      first_beat - first_acc, 1);
      chk({v.name, "/cyc_o_drain"},  bus.cyc_o, 0);
      chk({v.name, "/stb_o_drain"},  bus.stb_o, 0);
      if (v.stall_val >= 0) chk({v.name, "/halt_cycles"}, stall_good, v.stall_len);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"full",   224,   1'b0, -1,  0, 192,   0, 2};
      vecs[1] = '{"stall",  224,   1'b0, 100, 5, 192,   0, 2};
      vecs[2] = '{"stbtog", 224,   1'b1, -1,  0, 192,   0, 2};
      vecs[3] = '{"drop",   110,   1'b0, -1,  0, 94,    1, 1};
      vecs[4] = '{"sat",    24064, 1'b0, -1,  0, 19264, 0, 255};
      vecs[5] = '{"fresh",  144,   1'b0, -1,  0, 128,   0, 1};

      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.ack_i = 1'b1; bus.dat_in = '0;
      repeat (3) @(negedge clk);
      chk("reset/cyc_o",   bus.cyc_o, 0);
      chk("reset/stb_o",   bus.stb_o, 0);
      chk("reset/dat_out", bus.dat_out, 0);
      chk("reset/sym_err", bus.sym_err, 0);
      chk("reset/sym_idx", bus.sym_idx, 0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_pkt(vecs[i]);

      // Asynchronous reset in the middle of data symbol 1
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.ack_i = 1'b1; bus.dat_in = 32'(i);
      end
      @(negedge clk);
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      $display("pre-reset: stb_o=%0b dat_out=%0d sym_idx=%0d", bus.stb_o, bus.dat_out, bus.sym_idx);
      #2 rst = 1'b0;
      #1;
      chk("async_rst/cyc_o",   bus.cyc_o, 0);
      chk("async_rst/stb_o",   bus.stb_o, 0);
      chk("async_rst/dat_out", bus.dat_out, 0);
      chk("async_rst/sym_idx", bus.sym_idx, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_pkt(vecs[5]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cp_removal_framer.md
Name: cp_removal_framer

Overview:
- Sits directly downstream of the fine time synchroniser in the 802.11 OFDM RX chain.
- Its input stream starts at the first sample of the last long training symbol (LTS).
- It passes that 64-sample LTS unchanged, then strips the 16-sample cyclic prefix from every 80-sample data symbol.
- Each retained 64-sample block goes to the FFT stage with first/last/index framing markers, over the same cyc/stb/ack handshake used throughout the RX chain.

Parameters:
- NFFT, 64, samples retained per symbol (power of two).
- NCP, 16, cyclic-prefix samples discarded before each data symbol.
- NLTS, 64, samples of the leading LTS block (no prefix).
- IDXW, 8, width of sym_idx.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cyc_i  in  1  upstream packet/cycle valid
- stb_i  in  1  upstream sample strobe
- ack_o  out  1  sample accepted
- dat_in  in  32  sample: [31:16] I, [15:0] Q
- cyc_o  out  1  downstream packet valid
- stb_o  out  1  downstream sample strobe
- we_o  out  1  equals stb_o
- ack_i  in  1  downstream accept
- dat_out  out  32  retained sample
- sym_first  out  1  qualifies stb_o: first sample of a 64-block
- sym_last  out  1  qualifies stb_o: last sample of a 64-block
- sym_idx  out  IDXW  block index: 0 = LTS, data symbols 1.., saturates at all-ones
- sym_err  out  1  one-cycle pulse: packet ended mid-block
- out_halt  out  1  stb_o & ~ack_i

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, all counters 0.
- Handshake:
  - out_halt = stb_o & ~ack_i.
  - ack_o = cyc_i & stb_i & ~out_halt (combinational).
  - A sample is accepted when cyc_i & stb_i & ack_o.
  - Only accepted samples advance counters, including during CP.
- Output register (1-cycle latency):
  - On an accepted sample in LTS or DATA: dat_out<=dat_in, stb_o<=1, and sym_first/sym_last/sym_idx are loaded.
  - Else if ~out_halt: stb_o<=0, sym_first<=0, sym_last<=0.
  - While out_halt, dat_out, stb_o and all markers hold.
- FSM states: IDLE, LTS, CP, DATA, with sample counter cnt (7 bits).
- IDLE:
  - The first accepted sample goes to LTS as sample 0: cnt<=1, cyc_o<=1, sym_idx<=0, sym_first=1.
- LTS:
  - On the accepted sample with cnt==NLTS-1: sym_last=1, go to CP, cnt<=0.
- CP:
  - Accepted samples are consumed; no stb_o is produced.
  - At cnt==NCP-1, go to DATA, cnt<=0, and sym_idx increments (saturating) for the next block.
- DATA:
  - Sample cnt==0 carries sym_first=1.
  - Sample cnt==NFFT-1 carries sym_last=1, then go to CP.
- End of packet (cyc_i=0 in any non-IDLE state):
  - FSM goes to IDLE next cycle.
  - sym_err pulses for one cycle if the state is LTS or DATA with cnt!=0, or CP with cnt!=0.
  - cnt==0 in CP or DATA is a clean end; no pulse.
- cyc_o clears when cyc_i=0 and (stb_o=0 or ack_i=1), i.e. after the last output is drained.
- cyc_i is low for at least 1 cycle between packets. A new cyc_i rise restarts at sym_idx 0.
- sym_idx saturates at 2^IDXW-1 and never wraps.
- Simultaneous accept and halt cannot occur because ack_o is gated by out_halt.

Test Plan:
1. dat_in = running index 0..223, cyc_i/stb_i=1, ack_i=1 (64 LTS + 2×80 symbols):
   - exactly 192 stb_o beats, first dat_out=0 one cycle after the first accept;
   - values 64–79 and 144–159 are absent;
   - sym_first on values 0, 80, 160; sym_last on 63, 143, 223; sym_idx 0/1/2;
   - no sym_err; cyc_o drops after the last beat.
2. Same stream with ack_i held low 5 cycles mid-DATA (at value 100):
   - ack_o=0 and dat_out=100 held for those 5 cycles;
   - output sequence identical to test 1, with no loss or duplicate.
3. stb_i toggling 1-0 throughout, including inside CP: sample drop and markers identical to test 1 (counted on accepted samples only).
4. cyc_i dropped after 110 accepted samples (30 into symbol 1):
   - 94 output beats;
   - sym_err=1 for exactly one cycle;
   - FSM returns to IDLE and cyc_o=0 after drain.
5. rst asserted for 2 cycles mid-DATA, then a fresh packet:
   - outputs are 0 immediately, with no clock edge required;
   - the next packet starts with sym_idx=0 and sym_first on its first sample.
6. Packet of 64 + 300×80 samples with IDXW=8: sym_idx reaches 255 and stays 255 for the remaining symbols, with no wrap.
